// File: rtl/mem_io_responder.sv
// LC-3 memory-side responder: word RAM plus one memory-mapped I/O port,
// serviced after a fixed number of wait states with a one-cycle ready pulse.
module mem_io_responder #(
    parameter int          ADDR_W  = 8,
    parameter int          WAIT    = 2,
    parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MEM_EN,
    input  logic        WE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic [15:0] Switches,
    output logic [15:0] MDR_In,
    output logic        R,
    output logic [15:0] HEX,
    output logic        Busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAITING,
        DONE,
        HOLD
    } state_t;

    // Counter preload; unused when there are no wait states.
    localparam logic [3:0] WAIT_LD = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    state_t state;
    state_t state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;

    logic        we_q;
    logic [15:0] mar_q;
    logic [15:0] mdr_q;

    logic [15:0] ram [2**ADDR_W];

    logic              accept;
    logic              complete;
    logic              c_we;
    logic [15:0]       c_mar;
    logic [15:0]       c_mdr;
    logic              c_io;
    logic [ADDR_W-1:0] c_idx;

    // Next-state and counter logic; flags acceptance and completion edges.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        complete  = 1'b0;
        unique case (state)
            IDLE: begin
                if (MEM_EN) begin
                    accept = 1'b1;
                    if (WAIT == 0) begin
                        state_nxt = DONE;
                        complete  = 1'b1;
                    end else begin
                        state_nxt = WAITING;
                        cnt_nxt   = WAIT_LD;
                    end
                end
            end
            WAITING: begin
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                    complete  = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (!MEM_EN) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // With zero wait states the access completes on the accepting edge,
    // so the live request inputs are used instead of the latched copies.
    always_comb begin
        c_we  = (state == IDLE) ? WE  : we_q;
        c_mar = (state == IDLE) ? MAR : mar_q;
        c_mdr = (state == IDLE) ? MDR : mdr_q;
        c_io  = (c_mar == IO_ADDR);
        c_idx = c_mar[ADDR_W-1:0];
    end

    // State register and wait-state counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Request capture at acceptance; later input changes are ignored.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            we_q  <= 1'b0;
            mar_q <= 16'd0;
            mdr_q <= 16'd0;
        end else if (accept) begin
            we_q  <= WE;
            mar_q <= MAR;
            mdr_q <= MDR;
        end
    end

    // Registered outputs: ready pulse, busy flag, read data and HEX port.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            MDR_In <= 16'd0;
            R      <= 1'b0;
            HEX    <= 16'd0;
            Busy   <= 1'b0;
        end else begin
            R    <= (state_nxt == DONE);
            Busy <= (state_nxt != IDLE);
            if (complete) begin
                if (!c_we) begin
                    MDR_In <= c_io ? Switches : ram[c_idx];
                end else if (c_io) begin
                    HEX <= c_mdr;
                end
            end
        end
    end

    // RAM write port; contents survive reset, but a reset edge drops the write.
    always_ff @(posedge Clk) begin
        if (!Reset && complete && c_we && !c_io) begin
            ram[c_idx] <= c_mdr;
        end
    end

endmodule
